serial_to_parallel_nbit: RTL

Serial-in/parallel-out receiver that reassembles N-bit words from a one-bit serial stream produced by the team's parallel-load universal shift register (`ShiftParallel_NBIT`) when that register is used as a transmitter. The block samples the serial stream under a valid qualifier and a frame-start marker. It shifts bits in, in the direction selected at frame start, and presents each completed word on a registered parallel port with a valid/ready handshake. It sits between a serial link and word-wide datapath logic.

---
 rtl/shift_pkg.sv | 14 +
 rtl/serial_to_parallel_nbit_if.sv | 27 ++
 rtl/serial_to_parallel_nbit_frame_bit_counter.sv | 32 +++
 rtl/serial_to_parallel_nbit.sv | 85 ++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the serial shift transmit/receive blocks.
package shift_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int unsigned N_DEFAULT = 8;

endpackage

// File: rtl/serial_to_parallel_nbit_if.sv
// Serial input stream plus parallel word handshake for the serial-to-parallel receiver.
interface serial_to_parallel_nbit_if #(
  parameter int unsigned N = shift_pkg::N_DEFAULT
);

  logic         sin;
  logic         sin_valid;
  logic         frame_start;
  logic         dir;
  logic [N-1:0] pout;
  logic         pout_valid;
  logic         pout_ready;
  logic         overrun;
  logic         busy;

  // master drives the serial link and consumes words; slave is the receiver
  modport master (
    output sin, sin_valid, frame_start, dir, pout_ready,
    input  pout, pout_valid, overrun, busy
  );

  modport slave (
    input  sin, sin_valid, frame_start, dir, pout_ready,
    output pout, pout_valid, overrun, busy
  );

endinterface

// File: rtl/serial_to_parallel_nbit_frame_bit_counter.sv
// Mod-N bit counter for one frame; done flags the increment that reaches N.
module frame_bit_counter #(
  parameter int unsigned N = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load1,
  input  logic inc,
  output logic done
);

  localparam int unsigned CW = $clog2(N + 1);

  logic [CW-1:0] cnt;

  assign done = inc && !clr && !load1 && (cnt == CW'(N - 1));

  // Wraps to zero on the Nth bit so the next frame starts from a clean count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= CW'(1);
    end else if (inc) begin
      cnt <= done ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/serial_to_parallel_nbit.sv
// Serial-in/parallel-out receiver: frames N-bit words from a qualified serial
// stream and presents them on a registered valid/ready port.
module serial_to_parallel_nbit
  import shift_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input logic                     clk,
  input logic                     rst_n,
  serial_to_parallel_nbit_if.slave bus
);

  rx_state_t    state;
  logic [N-1:0] sreg;
  logic         dir_q;
  logic [N-1:0] pout_q;
  logic         pout_valid_q;
  logic         overrun_q;

  logic         start_c;
  logic         inc_c;
  logic         clr_c;
  logic         done_c;
  logic [N-1:0] word_c;

  function automatic logic [N-1:0] shift_in(input logic [N-1:0] cur,
                                            input logic         b,
                                            input logic         d);
    return (d == DIR_LEFT) ? {cur[N-2:0], b} : {b, cur[N-1:1]};
  endfunction

  // A qualified frame-start restarts the word from either state
  assign start_c = bus.sin_valid && bus.frame_start;
  assign inc_c   = (state == SHIFT) && bus.sin_valid && !bus.frame_start;
  assign clr_c   = (state == IDLE) && !start_c;
  assign word_c  = shift_in(sreg, bus.sin, dir_q);

  frame_bit_counter #(.N(N)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_c),
    .load1 (start_c),
    .inc   (inc_c),
    .done  (done_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sreg         <= '0;
      dir_q        <= DIR_LEFT;
      pout_q       <= '0;
      pout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (pout_valid_q && bus.pout_ready) begin
        pout_valid_q <= 1'b0;
      end
      if (start_c) begin
        state <= SHIFT;
        dir_q <= bus.dir;
        sreg  <= shift_in('0, bus.sin, bus.dir);
      end else if (inc_c) begin
        sreg <= word_c;
        if (done_c) begin
          state <= IDLE;
          // Buffer is free if empty or being drained on this same edge
          if (!pout_valid_q || bus.pout_ready) begin
            pout_q       <= word_c;
            pout_valid_q <= 1'b1;
          end else begin
            overrun_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.pout       = pout_q;
  assign bus.pout_valid = pout_valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = (state == SHIFT);

endmodule
